pattern_sequencer: RTL and testbench

Frame-synchronous controller that decides which test pattern the VGA projector draws. It takes the raw 3-bit pattern command from the Raspberry Pi GPIO pins, synchronizes and debounces it, and commits a new pattern only at a frame boundary, so no frame ever shows a torn mix of two patterns. After a commit it counts a settle period in frames, then raises an acknowledge line back to the Pi, which the Pi uses to trigger its camera capture. It sits between the GPIO pins and the pattern/colour generator, in the `clk25MHz` domain.

---
 rtl/pattern_seq_pkg.sv | 43 ++++
 rtl/gpio_debounce.sv | 68 ++++++
 rtl/pattern_sequencer.sv | 127 ++++++++++++
 tb/tb_pattern_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_seq_pkg.sv
// Shared pattern IDs, GPIO command codes, FSM states and decode helpers
// for pattern_sequencer.
package pattern_seq_pkg;

   localparam logic [1:0] PAT_VERT   = 2'd0;
   localparam logic [1:0] PAT_HORIZ  = 2'd1;
   localparam logic [1:0] PAT_SMILEY = 2'd2;
   localparam logic [1:0] PAT_BLANK  = 2'd3;

   // Bit order is {GPIO[4], GPIO[2], GPIO[0]}
   localparam logic [2:0] CMD_VERT   = 3'b000;
   localparam logic [2:0] CMD_HORIZ  = 3'b111;
   localparam logic [2:0] CMD_SMILEY = 3'b010;
   localparam logic [2:0] CMD_AUTO   = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PENDING,
      S_SETTLE,
      S_STABLE,
      S_AUTO
   } seq_state_e;

   // Auto-cycle is steered by the FSM, so its code draws blank here
   function automatic logic [1:0] decode_cmd(input logic [2:0] code);
      case (code)
         CMD_VERT:   return PAT_VERT;
         CMD_HORIZ:  return PAT_HORIZ;
         CMD_SMILEY: return PAT_SMILEY;
         CMD_AUTO:   return PAT_BLANK;
         default:    return PAT_BLANK;
      endcase
   endfunction

   function automatic logic [1:0] next_auto_pattern(input logic [1:0] pat);
      case (pat)
         PAT_VERT:  return PAT_HORIZ;
         PAT_HORIZ: return PAT_SMILEY;
         default:   return PAT_VERT;
      endcase
   endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Two-flop synchronizer plus stability counter; accepts a value after
// DEBOUNCE_CYCLES identical synchronized samples and pulses cmd_new on change.
module gpio_debounce #(
   parameter int unsigned WIDTH           = 3,
   parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] cmd_q,
   output logic             cmd_valid,
   output logic             cmd_new
);

   localparam int unsigned    CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync2_q, sync1_d, sync2_d, cmd_d;
   logic [1:0]       fill_q, fill_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             valid_q, valid_d, new_q, new_d;

   // Counter and accept look one stage ahead so cmd_q and cmd_new update
   // together; fill_q keeps reset-value sync flops from counting as samples.
   always_comb begin
      sync1_d = din;
      sync2_d = sync1_q;
      fill_d  = {fill_q[0], 1'b1};
      cnt_d   = cnt_q;
      cmd_d   = cmd_q;
      valid_d = valid_q;
      new_d   = 1'b0;
      if (!fill_q[1] || (sync1_q != sync2_q)) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CW'(1);
      end
      if (fill_q[1] && (cnt_d == CNT_MAX) && (!valid_q || (sync1_q != cmd_q))) begin
         cmd_d   = sync1_q;
         valid_d = 1'b1;
         new_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         fill_q  <= '0;
         cnt_q   <= '0;
         cmd_q   <= '0;
         valid_q <= 1'b0;
         new_q   <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         valid_q <= valid_d;
         new_q   <= new_d;
      end
   end

   assign cmd_valid = valid_q;
   assign cmd_new   = new_q;

endmodule

// File: rtl/pattern_sequencer.sv
// Frame-synchronous test-pattern controller with settle-time acknowledge.
// Optional auto-cycle mode on code 101 is enabled by PATTERN_SEQ_AUTOCYCLE_EN.
module pattern_sequencer
   import pattern_seq_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned SETTLE_FRAMES   = 2,
   parameter int unsigned DWELL_FRAMES    = 60
) (
   input  logic       clk25MHz,
   input  logic       reset,
   input  logic [2:0] gpio_sel,
   input  logic       frame_start,
   output logic [1:0] pattern,
   output logic       ack,
   output logic       auto_active
);

   localparam logic [7:0] SETTLE_N = 8'(SETTLE_FRAMES);
   localparam logic [7:0] DWELL_N  = 8'(DWELL_FRAMES);

   logic [2:0] cmd_q;
   logic       cmd_valid, cmd_new;

   seq_state_e state_q, state_d;
   logic [1:0] pattern_q, pattern_d;
   logic       ack_q, ack_d;
   logic       auto_q, auto_d;
   logic [7:0] frame_cnt_q, frame_cnt_d, frame_inc;

   gpio_debounce #(
      .WIDTH          (3),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk      (clk25MHz),
      .reset    (reset),
      .din      (gpio_sel),
      .cmd_q    (cmd_q),
      .cmd_valid(cmd_valid),
      .cmd_new  (cmd_new)
   );

   // cmd_q already carries a command arriving with frame_start, so a
   // same-cycle collision in PENDING commits the newest command.
   always_comb begin
      state_d     = state_q;
      pattern_d   = pattern_q;
      ack_d       = ack_q;
      auto_d      = auto_q;
      frame_cnt_d = frame_cnt_q;
      frame_inc   = (frame_cnt_q == 8'hFF) ? frame_cnt_q : frame_cnt_q + 8'd1;
      case (state_q)
         S_IDLE: begin
            if (cmd_new) state_d = S_PENDING;
         end
         S_PENDING: begin
            if (frame_start && cmd_valid) begin
               frame_cnt_d = '0;
               pattern_d   = decode_cmd(cmd_q);
               auto_d      = 1'b0;
               state_d     = S_SETTLE;
`ifdef PATTERN_SEQ_AUTOCYCLE_EN
               if (cmd_q == CMD_AUTO) begin
                  pattern_d = PAT_VERT;
                  auto_d    = 1'b1;
                  state_d   = S_AUTO;
               end
`endif
            end
         end
         S_SETTLE: begin
            if (cmd_new) begin
               state_d = S_PENDING;
               ack_d   = 1'b0;
            end else if (frame_start) begin
               frame_cnt_d = frame_inc;
               if (frame_inc >= SETTLE_N) begin
                  state_d = S_STABLE;
                  ack_d   = 1'b1;
               end
            end
         end
         S_STABLE: begin
            if (cmd_new) begin
               state_d = S_PENDING;
               ack_d   = 1'b0;
            end else if (frame_start) begin
               frame_cnt_d = frame_inc;
            end
         end
         S_AUTO: begin
            if (cmd_new) begin
               state_d = S_PENDING;
            end else if (frame_start) begin
               if (frame_inc >= DWELL_N) begin
                  frame_cnt_d = '0;
                  pattern_d   = next_auto_pattern(pattern_q);
               end else begin
                  frame_cnt_d = frame_inc;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk25MHz) begin
      if (reset) begin
         state_q     <= S_IDLE;
         pattern_q   <= PAT_BLANK;
         ack_q       <= 1'b0;
         auto_q      <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pattern_q   <= pattern_d;
         ack_q       <= ack_d;
         auto_q      <= auto_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign pattern     = pattern_q;
   assign ack         = ack_q;
   assign auto_active = auto_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench for pattern_sequencer: event-level reference model,
// directed corner sequences, a decode table and randomized GPIO traffic.
`timescale 1ns/1ps
module tb_pattern_sequencer;

   localparam int DB = 4;
   localparam int SF = 2;
   localparam int DW = 3;
   localparam int FP = 100;
`ifdef PATTERN_SEQ_AUTOCYCLE_EN
   localparam bit AUTO_EN = 1'b1;
`else
   localparam bit AUTO_EN = 1'b0;
`endif

   logic       clk25MHz = 1'b0;
   logic       reset;
   logic [2:0] gpio_sel;
   logic       frame_start;
   logic [1:0] pattern;
   logic       ack;
   logic       auto_active;

   always #20 clk25MHz = ~clk25MHz;

   pattern_sequencer #(
      .DEBOUNCE_CYCLES(DB),
      .SETTLE_FRAMES  (SF),
      .DWELL_FRAMES   (DW)
   ) dut (
      .clk25MHz   (clk25MHz),
      .reset      (reset),
      .gpio_sel   (gpio_sel),
      .frame_start(frame_start),
      .pattern    (pattern),
      .ack        (ack),
      .auto_active(auto_active)
   );

   int total = 0;
   int bad   = 0;
   int fcnt  = 0;

   // Reference model state: GPIO sample history, accepted command,
   // and the committed command with frames seen since its commit.
   logic [2:0] hist[$];
   bit         m_valid, m_acc_prev, m_pending, m_committed, m_auto;
   logic [2:0] m_cmd, m_ccode;
   int         m_frames;

   function automatic int ref_pat(input logic [2:0] c);
      if (c == 3'b000) return 0;
      if (c == 3'b111) return 1;
      if (c == 3'b010) return 2;
      return 3;
   endfunction

   task automatic model_reset();
      hist.delete();
      m_valid = 0; m_acc_prev = 0; m_pending = 0; m_committed = 0;
      m_auto = 0; m_frames = 0; m_cmd = '0; m_ccode = '0;
   endtask

   task automatic model_edge(input logic [2:0] g, input bit fs, input bit rst);
      bit acc, same;
      if (rst) begin
         model_reset();
         return;
      end
      if (m_pending && fs) begin
         m_pending   = 0;
         m_committed = 1;
         m_ccode     = m_cmd;
         m_frames    = 0;
         m_auto      = AUTO_EN && (m_cmd == 3'b101);
      end else if (m_acc_prev) begin
         m_pending = 1;
      end else if (m_committed && fs) begin
         m_frames++;
      end
      hist.push_back(g);
      if (hist.size() > DB + 1) void'(hist.pop_front());
      acc = 0;
      if (hist.size() == DB + 1) begin
         same = 1;
         for (int i = 1; i < DB; i++) if (hist[i] != hist[0]) same = 0;
         if (same && (!m_valid || hist[DB-1] != m_cmd)) begin
            acc     = 1;
            m_cmd   = hist[DB-1];
            m_valid = 1;
         end
      end
      m_acc_prev = acc;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      int ep, ea;
      @(posedge clk25MHz);
      model_edge(gpio_sel, frame_start, reset);
      #1;
      ep = !m_committed ? 3 : (m_auto ? (m_frames / DW) % 3 : ref_pat(m_ccode));
      ea = (m_committed && !m_pending && !m_auto && m_frames >= SF) ? 1 : 0;
      chk("model_pattern", int'(pattern), ep);
      chk("model_ack", int'(ack), ea);
      chk("model_auto", int'(auto_active), int'(m_auto));
      fcnt        = (fcnt + 1) % FP;
      frame_start = (fcnt == FP - 1);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_phase(input int p);
      for (int i = 0; i < FP && fcnt != p; i++) step();
   endtask

   typedef struct {
      logic [2:0] code;
      int         pat;
      int         ackv;
      int         autov;
   } vec_t;

   vec_t vecs[8];

   initial begin
      model_reset();
      reset = 1'b1; gpio_sel = 3'b000; frame_start = 1'b0;
      run(3);
      chk("reset_pattern", int'(pattern), 3);
      chk("reset_ack", int'(ack), 0);
      chk("reset_auto", int'(auto_active), 0);

      // Reset then command 010
      wait_phase(50);
      gpio_sel = 3'b010; reset = 1'b0;
      run(49);
      chk("first_cmd_before_frame", int'(pattern), 3);
      run(1);
      chk("first_cmd_commit", int'(pattern), 2);
      chk("first_cmd_ack_low", int'(ack), 0);
      run(199);
      chk("first_cmd_ack_pre", int'(ack), 0);
      run(1);
      chk("first_cmd_ack_rise", int'(ack), 1);

      // Settle on vertical, then glitch to 111 for 3 cycles
      gpio_sel = 3'b000;
      run(400);
      chk("vert_pattern", int'(pattern), 0);
      chk("vert_ack", int'(ack), 1);
      gpio_sel = 3'b111; run(3);
      gpio_sel = 3'b000; run(150);
      chk("glitch_pattern", int'(pattern), 0);
      chk("glitch_ack", int'(ack), 1);

      // Change in STABLE: ack falls exactly 6 cycles after the GPIO edge
      wait_phase(10);
      gpio_sel = 3'b111;
      run(5);
      chk("change_ack_still_high", int'(ack), 1);
      run(1);
      chk("change_ack_fall", int'(ack), 0);
      chk("change_pattern_held", int'(pattern), 0);
      wait_phase(99);
      chk("change_before_frame", int'(pattern), 0);
      step();
      chk("change_after_frame", int'(pattern), 1);

      // Collision: cmd_new(000) lands in the frame_start cycle while 010 pending
      wait_phase(10);
      gpio_sel = 3'b010;
      wait_phase(94);
      gpio_sel = 3'b000;
      run(5);
      chk("collision_before", int'(pattern), 1);
      step();
      chk("collision_commit", int'(pattern), 0);

      // Illegal code, then reset during SETTLE
      wait_phase(10);
      gpio_sel = 3'b011;
      run(300);
      chk("illegal_pattern", int'(pattern), 3);
      chk("illegal_ack", int'(ack), 1);
      wait_phase(10);
      gpio_sel = 3'b000;
      run(150);
      chk("settle_pattern", int'(pattern), 0);
      chk("settle_ack", int'(ack), 0);
      reset = 1'b1;
      step();
      chk("midreset_pattern", int'(pattern), 3);
      chk("midreset_ack", int'(ack), 0);
      chk("midreset_auto", int'(auto_active), 0);
      reset = 1'b0;

      if (AUTO_EN) begin
         wait_phase(10);
         gpio_sel = 3'b101;
         run(90);
         chk("auto_start_pattern", int'(pattern), 0);
         chk("auto_start_active", int'(auto_active), 1);
         chk("auto_start_ack", int'(ack), 0);
         run(300);
         chk("auto_step_pattern", int'(pattern), 1);
         chk("auto_step_active", int'(auto_active), 1);
         gpio_sel = 3'b000;
         run(400);
         chk("auto_exit_active", int'(auto_active), 0);
         chk("auto_exit_ack", int'(ack), 1);
      end

      // Decode table, each entry applied just after a frame boundary
      vecs[0] = '{3'b000, 0, 1, 0};
      vecs[1] = '{3'b001, 3, 1, 0};
      vecs[2] = '{3'b010, 2, 1, 0};
      vecs[3] = '{3'b011, 3, 1, 0};
      vecs[4] = '{3'b100, 3, 1, 0};
      if (AUTO_EN) vecs[5] = '{3'b101, 0, 0, 1};
      else         vecs[5] = '{3'b101, 3, 1, 0};
      vecs[6] = '{3'b110, 3, 1, 0};
      vecs[7] = '{3'b111, 1, 1, 0};
      gpio_sel = 3'b110;
      run(20);
      for (int v = 0; v < 8; v++) begin
         wait_phase(0);
         gpio_sel = vecs[v].code;
         run(320);
         chk($sformatf("table_pattern_%0d", v), int'(pattern), vecs[v].pat);
         chk($sformatf("table_ack_%0d", v), int'(ack), vecs[v].ackv);
         chk($sformatf("table_auto_%0d", v), int'(auto_active), vecs[v].autov);
      end

      // Randomized GPIO traffic with occasional resets
      for (int it = 0; it < 150; it++) begin
         int hold;
         if ($urandom_range(0, 24) == 0) begin
            reset = 1'b1;
            run(int'($urandom_range(1, 3)));
            reset = 1'b0;
         end
         gpio_sel = 3'($urandom_range(0, 7));
         hold = ($urandom_range(0, 9) < 3) ? int'($urandom_range(100, 350))
                                           : int'($urandom_range(1, 8));
         run(hold);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
